// File: rtl/result_uart_tx_if.sv
// Result-word handshake and serial-line bundle between the processing IP and result_uart_tx.
interface result_uart_tx_if;
    logic [31:0] data32;
    logic        flag_ready32;
    logic        UART_TX;
    logic        busy;
    logic        flag_sent32;
    logic        overrun;

    modport master (
        output data32,
        output flag_ready32,
        input  UART_TX,
        input  busy,
        input  flag_sent32,
        input  overrun
    );

    modport slave (
        input  data32,
        input  flag_ready32,
        output UART_TX,
        output busy,
        output flag_sent32,
        output overrun
    );
endinterface

// File: rtl/result_uart_tx.sv
// Serialises a 32-bit result word as back-to-back 8N1 bytes, LSB byte first.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum byte after the fourth data byte.
module result_uart_tx #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200
) (
    input  logic            clk,
    input  logic            rst,
    result_uart_tx_if.slave bus
);

    localparam int DIV    = CLK_FREQUENCY / BAUD_RATE;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int FRAME_W = NB * 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic                overrun_q, overrun_d;

    logic                baud_tick;
    logic                capture;
    logic                busy_int;
    logic                tx_int;
    logic [FRAME_W-1:0]  load_word;

`ifdef RESULT_TX_CHECKSUM_EN
    assign load_word = {bus.data32[7:0] ^ bus.data32[15:8] ^ bus.data32[23:16] ^ bus.data32[31:24],
                        bus.data32};
`else
    assign load_word = bus.data32;
`endif

    assign baud_tick = (baud_cnt_q == BAUD_W'(DIV - 1));
    assign busy_int  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    // DONE counts as not busy, so a word offered there starts the next frame without a gap.
    assign capture   = bus.flag_ready32 && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        overrun_d  = overrun_q | (bus.flag_ready32 & busy_int);
        tx_int     = 1'b1;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (capture) begin
                    state_d    = START;
                    shift_d    = load_word;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            START: begin
                tx_int = 1'b0;
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            DATA: begin
                tx_int = shift_q[0];
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    if (byte_cnt_q == 3'(NB - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        state_d    = START;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.UART_TX     = tx_int;
    assign bus.busy        = busy_int;
    assign bus.flag_sent32 = (state_q == DONE);
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Randomised self-checking bench for result_uart_tx against a cycle-offset line model.
// Build with RESULT_TX_CHECKSUM_EN defined to exercise the five-byte frame.
module tb_result_uart_tx;

    localparam int CLK_FREQUENCY = 1000000;
    localparam int BAUD_RATE     = 100000;
    localparam int DIV           = CLK_FREQUENCY / BAUD_RATE;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int FRAME_CYCLES = NB * 10 * DIV;

    logic clk = 1'b0;
    logic rst;

    result_uart_tx_if bus ();

    result_uart_tx #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .BAUD_RATE    (BAUD_RATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          cycleCount  = 0;
    bit          modelActive = 1'b0;
    int          modelOffset = 0;
    logic [31:0] modelWord   = '0;
    bit          modelOverrun = 1'b0;
    int          captureCycle = 0;
    logic [7:0]  rxByte      = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cycleCount, observed, expected);
        end
    endtask

    // Byte idx of the frame: four data bytes LSB first, then the XOR checksum.
    function automatic logic [7:0] expectedByte(input logic [31:0] word, input int idx);
        if (idx >= 4)
            return word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
        return word[idx*8 +: 8];
    endfunction

    // Line level offset cycles after capture (offset 1 is the first start-bit cycle).
    function automatic logic expectedLine(input logic [31:0] word, input int offset);
        int         bitIdx;
        int         pos;
        logic [7:0] b;
        bitIdx = (offset - 1) / DIV;
        pos    = bitIdx % 10;
        b      = expectedByte(word, bitIdx / 10);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic applyStimulus(input logic r, input logic ready, input logic [31:0] data);
        logic expTx;
        logic expBusy;
        logic expSent;
        bit   busyNow;
        int   pos;
        rst              = r;
        bus.flag_ready32 = ready;
        bus.data32       = data;
        @(negedge clk);
        expTx   = 1'b1;
        expBusy = 1'b0;
        expSent = 1'b0;
        if (modelActive) begin
            if (modelOffset <= FRAME_CYCLES) begin
                expBusy = 1'b1;
                expTx   = expectedLine(modelWord, modelOffset);
                if (((modelOffset - 1) % DIV) == DIV / 2) begin
                    pos = ((modelOffset - 1) / DIV) % 10;
                    if (pos >= 1 && pos <= 8)
                        rxByte[pos-1] = bus.UART_TX;
                    if (pos == 9)
                        checkOutput("decodedByte", rxByte, expectedByte(modelWord, (modelOffset - 1) / DIV / 10));
                end
            end else begin
                expSent = 1'b1;
            end
        end
        checkOutput("UART_TX", bus.UART_TX, expTx);
        checkOutput("busy", bus.busy, expBusy);
        checkOutput("flag_sent32", bus.flag_sent32, expSent);
        checkOutput("overrun", bus.overrun, modelOverrun);
        if (bus.flag_sent32 === 1'b1)
            checkOutput("sentLatency", cycleCount - captureCycle, FRAME_CYCLES + 1);

        if (r) begin
            modelActive  = 1'b0;
            modelOverrun = 1'b0;
        end else begin
            busyNow = modelActive && (modelOffset <= FRAME_CYCLES);
            if (ready && !busyNow) begin
                modelActive  = 1'b1;
                modelOffset  = 1;
                modelWord    = data;
                captureCycle = cycleCount;
            end else begin
                if (ready) modelOverrun = 1'b1;
                if (modelActive) begin
                    modelOffset++;
                    if (modelOffset > FRAME_CYCLES + 1) modelActive = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom);
    endtask

    initial begin
        rst              = 1'b1;
        bus.flag_ready32 = 1'b0;
        bus.data32       = '0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset and idle");
        applyStimulus(1'b1, 1'b1, $urandom);
        idleCycles(50);

        $display("[TB] single word 12345678");
        applyStimulus(1'b0, 1'b1, 32'h12345678);
        idleCycles(FRAME_CYCLES + 10);

        $display("[TB] word A5A50F0F");
        applyStimulus(1'b0, 1'b1, 32'hA5A5_0F0F);
        idleCycles(FRAME_CYCLES + 10);

        $display("[TB] overrun mid-frame");
        applyStimulus(1'b0, 1'b1, 32'h0BADF00D);
        idleCycles(99);
        applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
        idleCycles(FRAME_CYCLES + 10);
        checkOutput("overrunSticky", bus.overrun, 1'b1);
        applyStimulus(1'b1, 1'b0, $urandom);

        $display("[TB] reset mid-frame then 00000001");
        applyStimulus(1'b0, 1'b1, 32'hCAFEF00D);
        idleCycles(149);
        applyStimulus(1'b1, 1'b0, $urandom);
        applyStimulus(1'b0, 1'b1, 32'h00000001);
        idleCycles(FRAME_CYCLES + 10);

        $display("[TB] new word in DONE cycle");
        applyStimulus(1'b0, 1'b1, $urandom);
        for (int i = 0; i < FRAME_CYCLES + 5 && !(modelActive && modelOffset == FRAME_CYCLES + 1); i++)
            applyStimulus(1'b0, 1'b0, $urandom);
        checkOutput("reachedDone", modelOffset, FRAME_CYCLES + 1);
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);
        idleCycles(FRAME_CYCLES + 10);

        $display("[TB] flag_ready32 held high");
        for (int i = 0; i < 2 * FRAME_CYCLES + 30; i++) applyStimulus(1'b0, 1'b1, $urandom);
        idleCycles(FRAME_CYCLES + 5);
        applyStimulus(1'b1, 1'b0, $urandom);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 2, $urandom);
        idleCycles(FRAME_CYCLES + 5);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 100000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port data32  input  32  result word from the processing IP.
REQ-006 SHALL have port flag_ready32  input  1  result-valid pulse; data32 is valid in the same cycle.
REQ-007 SHALL have port UART_TX  output  1  serial line; 8N1 framing; idle high.
REQ-008 SHALL have port busy  output  1  high while a word is being sent.
REQ-009 SHALL have port flag_sent32  output  1  one-cycle pulse after the last stop bit completes.
REQ-010 SHALL have port overrun  output  1  sticky flag; flag_ready32 arrived while busy.

Function
REQ-011 SHALL use bit period DIV = CLK_FREQUENCY/BAUD_RATE (integer division) clk cycles for every start, data and stop bit; 868 at defaults.
REQ-012 SHALL capture data32 into an internal register in the cycle where flag_ready32=1 and busy=0.
REQ-013 SHALL drive UART_TX low (start bit) from the cycle after capture; busy SHALL rise in that same cycle.
REQ-014 SHALL send bytes least-significant first: data32[7:0], [15:8], [23:16], [31:24]; bits within a byte LSB first.
REQ-015 SHALL send each byte as 1 start bit (0), 8 data bits, 1 stop bit (1), with no idle gap between consecutive bytes.
REQ-016 SHALL run FSM states IDLE -> START -> DATA (8 bits) -> STOP -> (START of next byte | DONE) -> IDLE; DONE lasts exactly one cycle.
REQ-017 SHALL assert flag_sent32 for exactly one cycle in DONE, i.e. 1 + NB*10*DIV cycles after the capture cycle (NB = bytes per frame); busy SHALL fall in that cycle.
REQ-018 SHALL accept a new flag_ready32 in the DONE cycle or any later cycle; consecutive words are sent back-to-back.
REQ-019 SHALL ignore flag_ready32 while busy=1 (captured word and line timing unaffected) and set overrun=1 until reset.
REQ-020 SHALL treat flag_ready32 held high for several cycles in IDLE as a single capture on its first cycle, and a new capture once DONE is reached if still high.
REQ-021 SHALL hold UART_TX high in IDLE and DONE.

Reset
REQ-022 SHALL, with rst=1 at a clk edge, force in the next cycle: state IDLE, UART_TX=1, busy=0, flag_sent32=0, overrun=0, bit/byte/baud counters 0.
REQ-023 SHALL abort any frame in progress when rst is asserted mid-frame; no flag_sent32 is generated for the aborted word.
REQ-024 SHALL ignore flag_ready32 in any cycle where rst=1.

Configuration
REQ-025 SHALL, when macro RESULT_TX_CHECKSUM_EN is defined, append a 5th byte = XOR of the four data bytes after data32[31:24] (NB=5); when undefined, send exactly 4 bytes (NB=4) and contain no checksum logic.

Verification (sim parameters CLK_FREQUENCY=1000000, BAUD_RATE=100000, DIV=10)
REQ-026 SHALL cover: reset then idle 50 cycles -> UART_TX=1, busy=0, flag_sent32=0, overrun=0 throughout.
REQ-027 SHALL cover: data32=32'h12345678 with a 1-cycle flag_ready32 -> decoded bytes 78,56,34,12, each bit 10 cycles; flag_sent32 pulse 401 cycles after capture (checksum off).
REQ-028 SHALL cover: RESULT_TX_CHECKSUM_EN defined, data32=32'hA5A5_0F0F -> bytes 0F,0F,A5,A5,00; flag_sent32 501 cycles after capture.
REQ-029 SHALL cover: second flag_ready32 with data32=32'hDEADBEEF 100 cycles into a frame -> first word sent unchanged, overrun=1, no second frame.
REQ-030 SHALL cover: rst pulse 150 cycles into a frame -> UART_TX=1 and busy=0 the next cycle, no flag_sent32; following word 32'h00000001 sends bytes 01,00,00,00 correctly.
REQ-031 SHALL cover: flag_ready32 in the DONE cycle with data32=32'hFFFFFFFF -> new start bit the next cycle, bytes FF x4, no idle gap, overrun=0.
